// File: rtl/max_exec.sv
// Execution/writeback stage for max commands: one-cycle signed max, in-order result FIFO, credit-based issue.
// Optional MAX_EXEC_RELU_EN: clamps negative results to zero (fused ReLU).
module max_exec #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    logic              s1_valid_q, s1_valid_d;
    wb_ent_t           s1_q, s1_d;
    wb_ent_t           mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [OCC_W-1:0]  occ_d;
    logic [CNT_W-1:0]  done_q, done_d;
    wb_ent_t           last_q, last_d;
    logic              ready_q, ready_d;
    logic              wb_valid_q, wb_valid_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] max_val;
    wb_ent_t           head;

    assign head = mem_q[rd_ptr_q];

    // Signed compare; on a tie operand a wins.
    always_comb begin
        max_val = ($signed(issue_a) >= $signed(issue_b)) ? issue_a : issue_b;
`ifdef MAX_EXEC_RELU_EN
        if (max_val[DATA_W-1]) begin
            max_val = '0;
        end
`endif
    end

    // Next-state: stage 1, FIFO pointers, occupancy-derived status.
    always_comb begin
        accept     = issue_valid && ready_q;
        push       = s1_valid_q;
        pop        = wb_valid_q && wb_ready;

        s1_valid_d = accept;
        s1_d       = s1_q;
        if (accept) begin
            s1_d = '{addr: issue_dst, data: max_val};
        end

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + OCC_W'(push) - OCC_W'(pop);
        done_d     = done_q + CNT_W'(pop);
        last_d     = pop ? head : last_q;

        // Credits cover both the stage-1 slot and the FIFO, so an accepted command always has a home.
        occ_d      = count_d + OCC_W'(s1_valid_d);
        ready_d    = (occ_d < OCC_W'(DEPTH));
        busy_d     = (occ_d != '0);
        wb_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= '0;
            last_q     <= '0;
            ready_q    <= 1'b1;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            wb_valid_q <= wb_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_q;
        end
    end

    assign issue_ready = ready_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_valid_q ? head.addr : last_q.addr;
    assign wb_data     = wb_valid_q ? head.data : last_q.data;
    assign busy        = busy_q;
    assign done_cnt    = done_q;

endmodule
